grid_stream_loader: RTL

Synthesizable loader that turns a byte stream of grid text into packed occupancy-bit writes to one or more `mem` banks. It replaces the behavioural load loop now used in bench code, so grid initialisation runs in hardware ahead of the `freemachine` instances. It is generalised in chunk width, column limit, rows per bank, bank count and match character. It also provides occupancy counting, row/column accounting and overflow reporting.

---
 rtl/grid_stream_loader_pkg.sv | 22 ++
 rtl/grid_stream_loader_if.sv | 30 +++
 rtl/grid_stream_loader_bank_write_port.sv | 90 +++++++++
 rtl/grid_stream_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/grid_stream_loader_pkg.sv
// Shared constants, default geometry and state encoding for the grid stream loader.
package grid_stream_loader_pkg;

   localparam int TX_DATA_WIDTH   = 8;
   localparam int GRID_MAX_COLS   = 64;
   localparam int GRID_BANK_DEPTH = 16;
   localparam int BANK_ADDR_WIDTH = 4;
   localparam int COL_ADDR_WIDTH  = 6;

   localparam logic [7:0] ASCII_NL           = 8'h0A;
   localparam logic [7:0] DEFAULT_MATCH_CHAR = 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WAIT_IDLE,
      ST_WRITE_REQ,
      ST_WRITE_REL,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/grid_stream_loader_if.sv
// Bank write bus between a loader (master) and a mem bank (slave).
interface grid_stream_loader_if
   import grid_stream_loader_pkg::*;
#(
   parameter int TX_W       = TX_DATA_WIDTH,
   parameter int BANK_SEL_W = 1
) ();

   logic                       write_en_out;
   logic                       read_en_out;
   logic [BANK_ADDR_WIDTH-1:0] row_addr_out;
   logic [COL_ADDR_WIDTH-1:0]  col_addr_out;
   logic [TX_W-1:0]            partial_vec_out;
   logic [BANK_SEL_W-1:0]      bank_sel_out;
   logic                       ack_in;
   logic                       busy_in;

   modport master (
      output write_en_out, read_en_out, row_addr_out, col_addr_out,
             partial_vec_out, bank_sel_out,
      input  ack_in, busy_in
   );

   modport slave (
      input  write_en_out, read_en_out, row_addr_out, col_addr_out,
             partial_vec_out, bank_sel_out,
      output ack_in, busy_in
   );

endinterface

// File: rtl/grid_stream_loader_bank_write_port.sv
// Registered single-chunk bank write: wait for idle, request until ack, release until quiet.
module bank_write_port
   import grid_stream_loader_pkg::*;
#(
   parameter int TX_W       = TX_DATA_WIDTH,
   parameter int BANK_SEL_W = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req,
   input  logic [BANK_ADDR_WIDTH-1:0] req_row,
   input  logic [COL_ADDR_WIDTH-1:0]  req_col,
   input  logic [BANK_SEL_W-1:0]      req_bank,
   input  logic [TX_W-1:0]            req_vec,
   output logic                       ack_seen,
   output logic                       done,
   output logic [TX_W-1:0]            held_vec,
   grid_stream_loader_if.master       bus
);

   loader_state_t              state_q, state_d;
   logic [BANK_ADDR_WIDTH-1:0] row_q, row_d;
   logic [COL_ADDR_WIDTH-1:0]  col_q, col_d;
   logic [BANK_SEL_W-1:0]      bank_q, bank_d;
   logic [TX_W-1:0]            vec_q, vec_d;

   // Handshake state and held write address/data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         bank_q  <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         bank_q  <= bank_d;
         vec_q   <= vec_d;
      end
   end

   // Next handshake step; address/data only captured on a new request.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      bank_d   = bank_q;
      vec_d    = vec_q;
      ack_seen = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               row_d   = req_row;
               col_d   = req_col;
               bank_d  = req_bank;
               vec_d   = req_vec;
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (!bus.busy_in) state_d = ST_WRITE_REQ;
         end
         ST_WRITE_REQ: begin
            if (bus.ack_in) begin
               ack_seen = 1'b1;
               state_d  = ST_WRITE_REL;
            end
         end
         ST_WRITE_REL: begin
            if (!bus.busy_in && !bus.ack_in) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.write_en_out    = (state_q == ST_WRITE_REQ);
   assign bus.read_en_out     = 1'b0;
   assign bus.row_addr_out    = row_q;
   assign bus.col_addr_out    = col_q;
   assign bus.bank_sel_out    = bank_q;
   assign bus.partial_vec_out = vec_q;
   assign held_vec            = vec_q;

endmodule

// File: rtl/grid_stream_loader.sv
// Grid text byte stream to packed occupancy-bit bank writes, with row/column/count accounting.
module grid_stream_loader
   import grid_stream_loader_pkg::*;
#(
   parameter int         TX_W          = TX_DATA_WIDTH,
   parameter int         MAX_COLS      = GRID_MAX_COLS,
   parameter int         ROWS_PER_BANK = GRID_BANK_DEPTH,
   parameter int         NUM_BANKS     = 1,
   parameter logic [7:0] MATCH_CHAR    = DEFAULT_MATCH_CHAR,
   parameter int         BANK_SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  char_valid,
   input  logic [7:0]                            char_in,
   output logic                                  char_ready,
   input  logic                                  eof_in,
   grid_stream_loader_if.master                  bank,
   output logic                                  done_out,
   output logic [BANK_ADDR_WIDTH+BANK_SEL_W-1:0] rows_out,
   output logic [COL_ADDR_WIDTH:0]               cols_out,
   output logic [31:0]                           count_out,
   output logic [1:0]                            error_out
);

   localparam int CW = COL_ADDR_WIDTH + 1;
   localparam int RW = BANK_ADDR_WIDTH + BANK_SEL_W;
   localparam logic [CW-1:0]              TXW_C      = CW'(TX_W);
   localparam logic [CW-1:0]              MAXC_C     = CW'(MAX_COLS);
   localparam logic [RW-1:0]              ROW_LIMIT  = RW'(NUM_BANKS * ROWS_PER_BANK);
   localparam logic [BANK_ADDR_WIDTH-1:0] LAST_LOCAL = BANK_ADDR_WIDTH'(ROWS_PER_BANK - 1);

   loader_state_t              state_q, state_d;
   logic [CW-1:0]              col_q, col_d;
   logic [TX_W-1:0]            chunk_q, chunk_d;
   logic [BANK_ADDR_WIDTH-1:0] row_q, row_d;
   logic [BANK_SEL_W-1:0]      bank_q, bank_d;
   logic [RW-1:0]              rows_q, rows_d;
   logic [CW-1:0]              cols_q, cols_d;
   logic [31:0]                count_q, count_d;
   logic [1:0]                 err_q, err_d;
   logic                       pend_nl_q, pend_nl_d;
   logic                       pend_eof_q, pend_eof_d;

   logic [CW-1:0]   col_n, flush_base, end_cols;
   logic [TX_W-1:0] chunk_n;
   logic            line_end, flush, end_row, wr_req;
   logic            wr_ack_seen, wr_done;
   logic [TX_W-1:0] wr_held_vec;
   logic [31:0]     ones;

   bank_write_port #(
      .TX_W       (TX_W),
      .BANK_SEL_W (BANK_SEL_W)
   ) u_wr (
      .clock    (clock),
      .reset    (reset),
      .req      (wr_req),
      .req_row  (row_q),
      .req_col  (flush_base[COL_ADDR_WIDTH-1:0]),
      .req_bank (bank_q),
      .req_vec  (chunk_n),
      .ack_seen (wr_ack_seen),
      .done     (wr_done),
      .held_vec (wr_held_vec),
      .bus      (bank)
   );

   // Stream FSM state, line position, accounting and sticky errors.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         chunk_q    <= '0;
         row_q      <= '0;
         bank_q     <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         count_q    <= '0;
         err_q      <= '0;
         pend_nl_q  <= 1'b0;
         pend_eof_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         chunk_q    <= chunk_d;
         row_q      <= row_d;
         bank_q     <= bank_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         count_q    <= count_d;
         err_q      <= err_d;
         pend_nl_q  <= pend_nl_d;
         pend_eof_q <= pend_eof_d;
      end
   end

   // Byte decode, flush decisions and row bookkeeping.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      chunk_d    = chunk_q;
      row_d      = row_q;
      bank_d     = bank_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      count_d    = count_q;
      err_d      = err_q;
      pend_nl_d  = pend_nl_q;
      pend_eof_d = pend_eof_q;
      col_n      = col_q;
      chunk_n    = chunk_q;
      line_end   = 1'b0;
      flush      = 1'b0;
      flush_base = '0;
      end_row    = 1'b0;
      end_cols   = col_q;
      wr_req     = 1'b0;

      ones = '0;
      for (int unsigned i = 0; i < TX_W; i++) ones = ones + 32'(wr_held_vec[i]);
      if (wr_ack_seen) count_d = count_q + ones;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_ACCEPT;
               col_d      = '0;
               chunk_d    = '0;
               row_d      = '0;
               bank_d     = '0;
               rows_d     = '0;
               cols_d     = '0;
               count_d    = '0;
               err_d      = '0;
               pend_nl_d  = 1'b0;
               pend_eof_d = 1'b0;
            end
         end
         ST_ACCEPT: begin
            if (char_valid) begin
               if (char_in == ASCII_NL) begin
                  line_end = (col_q != '0);
               end else if (rows_q >= ROW_LIMIT) begin
                  err_d[1] = 1'b1;
               end else if (col_q >= MAXC_C) begin
                  err_d[0] = 1'b1;
               end else begin
                  for (int unsigned i = 0; i < TX_W; i++)
                     if (CW'(i) == (col_q % TXW_C)) chunk_n[i] = (char_in == MATCH_CHAR);
                  col_n = col_q + CW'(1);
                  if ((col_n % TXW_C) == '0) begin
                     flush      = 1'b1;
                     flush_base = col_q - (col_q % TXW_C);
                  end
               end
            end
            // eof acts as a newline applied after this cycle's byte; at most one
            // flush is needed because a full-chunk flush leaves no partial bits.
            if (eof_in && !line_end && col_n != '0) line_end = 1'b1;
            if (line_end && !flush && (col_n % TXW_C) != '0) begin
               flush      = 1'b1;
               flush_base = col_n - (col_n % TXW_C);
            end
            col_d = col_n;
            if (flush) begin
               // The write port holds its own copy, so the chunk is free again now.
               wr_req     = 1'b1;
               chunk_d    = '0;
               pend_nl_d  = line_end;
               pend_eof_d = eof_in;
               state_d    = ST_WAIT_IDLE;
            end else begin
               chunk_d  = chunk_n;
               end_row  = line_end;
               end_cols = col_n;
               if (eof_in) state_d = ST_DONE;
            end
         end
         ST_WAIT_IDLE: begin
            if (wr_done) begin
               end_row    = pend_nl_q;
               pend_nl_d  = 1'b0;
               pend_eof_d = 1'b0;
               state_d    = pend_eof_q ? ST_DONE : ST_ACCEPT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (end_row) begin
         rows_d  = rows_q + RW'(1);
         col_d   = '0;
         chunk_d = '0;
         if (rows_q == '0) cols_d = end_cols;
         if (row_q == LAST_LOCAL) begin
            row_d  = '0;
            bank_d = bank_q + BANK_SEL_W'(1);
         end else begin
            row_d = row_q + BANK_ADDR_WIDTH'(1);
         end
      end
   end

   assign char_ready = (state_q == ST_ACCEPT);
   assign done_out   = (state_q == ST_DONE);
   assign rows_out   = rows_q;
   assign cols_out   = cols_q;
   assign count_out  = count_q;
   assign error_out  = err_q;

endmodule
